// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide sequencer sharing the ALU's 33-bit multdiv adder.
// Define IBEX_MULTDIV_DIV_EN to build the divide datapath; without it divide ops return all ones.
module ibex_multdiv_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        alu_sel_o,
    input  logic [33:0] alu_sum_ext_i
);

    typedef enum logic [2:0] {
        IDLE, INIT_A, INIT_B, LOOP, FIX_LO, FIX_HI, DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e      state_q, state_d;
    op_e         op_q, op_d, op_in;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] result_q, result_d;
    logic [32:0] bmag_q, bmag_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d, neg_res_q, neg_res_d;

    logic [32:0] sum;
    logic        unused_sum_lsb;
    logic        is_div, neg_lo, neg_hi, res_is_lo;
    logic        start_sign_a, start_sign_b;
    logic [32:0] alu_a, alu_b;
    logic        alu_sel;
`ifdef IBEX_MULTDIV_DIV_EN
    logic [32:0] rem_shift;
    logic        acc;
`endif

    assign sum            = alu_sum_ext_i[33:1];
    assign unused_sum_lsb = alu_sum_ext_i[0];
    assign op_in          = op_e'(op_i);
    assign is_div         = op_q[2];

    assign start_sign_a = op_a_i[31] &
                          (op_in == OP_MULH || op_in == OP_MULHSU || op_in == OP_DIV || op_in == OP_REM);
    assign start_sign_b = op_b_i[31] & (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);

    // Remainders keep their sign through hi; only products and quotients negate lo.
    assign neg_lo = neg_res_q & ~(is_div & op_q[1]);
`ifdef IBEX_MULTDIV_DIV_EN
    assign rem_shift = {hi_q, lo_q[31]};
    assign neg_hi    = (neg_res_q & ~is_div) | (is_div & op_q[1] & sign_a_q);
`else
    assign neg_hi    = neg_res_q & ~is_div;
`endif
    assign res_is_lo = is_div ? ~op_q[1] : (op_q[1:0] == 2'b00);

    // ALU operand drive depends on registered state only, keeping the external adder loop acyclic.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a missed path would infer a latch.
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = 1'b0;
        case (state_q)
            INIT_A: begin
                alu_sel = 1'b1;
                if (sign_a_q) begin
                    alu_a = {1'b0, ~a_q};
                    alu_b = 33'd1;
                end
            end
            INIT_B: begin
                alu_sel = 1'b1;
`ifdef IBEX_MULTDIV_DIV_EN
                if (is_div) begin
                    if (!sign_b_q) begin
                        alu_a = ~{1'b0, b_q};
                        alu_b = 33'd1;
                    end
                end else if (sign_b_q) begin
                    alu_a = ~{b_q[31], b_q};
                    alu_b = 33'd1;
                end
`else
                if (sign_b_q) begin
                    alu_a = ~{b_q[31], b_q};
                    alu_b = 33'd1;
                end
`endif
            end
            LOOP: begin
                alu_sel = 1'b1;
`ifdef IBEX_MULTDIV_DIV_EN
                if (is_div) begin
                    alu_a = rem_shift;
                    alu_b = bmag_q;
                end else begin
                    alu_a = {1'b0, hi_q};
                    alu_b = lo_q[0] ? bmag_q : 33'd0;
                end
`else
                alu_a = {1'b0, hi_q};
                alu_b = lo_q[0] ? bmag_q : 33'd0;
`endif
            end
            FIX_LO: begin
                alu_sel = 1'b1;
                if (neg_lo) begin
                    alu_a = {1'b0, ~lo_q};
                    alu_b = 33'd1;
                end
            end
            FIX_HI: begin
                alu_sel = 1'b1;
                if (neg_hi) begin
                    alu_a = {1'b0, ~hi_q};
                    alu_b = is_div ? 33'd1 : {32'b0, carry_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        bmag_d    = bmag_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        neg_res_d = neg_res_q;
        result_d  = result_q;
`ifdef IBEX_MULTDIV_DIV_EN
        acc       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d      = op_in;
                    a_d       = op_a_i;
                    b_d       = op_b_i;
                    hi_d      = '0;
                    cnt_d     = '0;
                    sign_a_d  = start_sign_a;
                    sign_b_d  = start_sign_b;
                    neg_res_d = (start_sign_a ^ start_sign_b) & ~(op_i[2] && op_b_i == 32'd0);
`ifdef IBEX_MULTDIV_DIV_EN
                    state_d   = INIT_A;
`else
                    if (op_i[2]) begin
                        state_d  = DONE;
                        result_d = '1;
                    end else begin
                        state_d  = INIT_A;
                    end
`endif
                end
            end
            INIT_A: begin
                lo_d    = sign_a_q ? sum[31:0] : a_q;
                state_d = INIT_B;
            end
            INIT_B: begin
`ifdef IBEX_MULTDIV_DIV_EN
                if (is_div) bmag_d = sign_b_q ? {b_q[31], b_q} : sum;
                else        bmag_d = sign_b_q ? sum : {1'b0, b_q};
`else
                bmag_d = sign_b_q ? sum : {1'b0, b_q};
`endif
                state_d = LOOP;
            end
            LOOP: begin
`ifdef IBEX_MULTDIV_DIV_EN
                if (is_div) begin
                    // Restoring step: keep the difference when the trial subtract does not borrow.
                    acc  = rem_shift[32] | ~sum[32];
                    hi_d = acc ? sum[31:0] : rem_shift[31:0];
                    lo_d = {lo_q[30:0], acc};
                end else begin
                    hi_d = sum[32:1];
                    lo_d = {sum[0], lo_q[31:1]};
                end
`else
                hi_d = sum[32:1];
                lo_d = {sum[0], lo_q[31:1]};
`endif
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX_LO;
            end
            FIX_LO: begin
                if (neg_lo) begin
                    lo_d    = sum[31:0];
                    carry_d = sum[32];
                end else begin
                    carry_d = ~is_div;
                end
                state_d = FIX_HI;
            end
            FIX_HI: begin
                if (neg_hi) hi_d = sum[31:0];
                result_d = res_is_lo ? lo_q : (neg_hi ? sum[31:0] : hi_q);
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            bmag_q    <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            neg_res_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            bmag_q    <= bmag_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            neg_res_q <= neg_res_d;
            result_q  <= result_d;
        end
    end

    assign ready_o         = (state_q == IDLE);
    assign valid_o         = (state_q == DONE);
    assign result_o        = result_q;
    assign alu_operand_a_o = alu_a;
    assign alu_operand_b_o = alu_b;
    assign alu_sel_o       = alu_sel;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter: directed RV32M cases plus random ops
// against an arithmetic reference model, with abort, busy-start and reset checks.
module tb_ibex_multdiv_iter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        abort_i;
    logic [2:0]  op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic        alu_sel_o;
    logic [33:0] alu_sum_ext_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    // Combinational ALU adder: S = (A + B) mod 2^33 in bits [33:1].
    assign alu_sum_ext_i = {alu_operand_a_o + alu_operand_b_o, 1'b1};

    ibex_multdiv_iter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .op_i            (op_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .result_o        (result_o),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_sel_o       (alu_sel_o),
        .alu_sum_ext_i   (alu_sum_ext_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        ia = a;
        ib = b;
`ifndef IBEX_MULTDIV_DIV_EN
        if (op[2]) return 32'hFFFF_FFFF;
`endif
        case (op)
            3'd0: begin p = za * zb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op);
`ifdef IBEX_MULTDIV_DIV_EN
        return (op == 3'd0) ? 37 : 37;
`else
        return op[2] ? 1 : 37;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic check_idle(input string tag, input logic [31:0] exp_res);
        check({tag, " ready"},  64'(ready_o), 64'd1);
        check({tag, " valid"},  64'(valid_o), 64'd0);
        check({tag, " result"}, 64'(result_o), 64'(exp_res));
        check({tag, " alu_a"},  64'(alu_operand_a_o), 64'd0);
        check({tag, " alu_b"},  64'(alu_operand_b_o), 64'd0);
        check({tag, " sel"},    64'(alu_sel_o), 64'd0);
    endtask

    // Issue one request and wait (bounded) for valid_o; optionally poke start_i while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit busy_poke);
        string tag;
        int    cycles;
        int    extra;
        bit    busy_bad;
        bit    sel_seen;
        tag = $sformatf("op%0d %h/%h", op, a, b);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        @(negedge clk_i);
        start_i  = 1'b0;
        op_i     = 3'($urandom);
        op_a_i   = $urandom;
        op_b_i   = $urandom;
        cycles   = 1;
        busy_bad = 1'b0;
        sel_seen = 1'b0;
        while (valid_o !== 1'b1 && cycles < 60) begin
            if (ready_o !== 1'b0) busy_bad = 1'b1;
            sel_seen |= alu_sel_o;
            if (busy_poke && cycles == 5) begin
                start_i = 1'b1;
                op_i    = 3'd3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cycles++;
        end
        sel_seen |= alu_sel_o;
        check({tag, " latency"}, 64'(cycles), 64'(model_latency(op)));
        check({tag, " result"},  64'(result_o), 64'(model_result(op, a, b)));
        check({tag, " busy"},    64'(busy_bad | ready_o), 64'd0);
        check({tag, " sel"},     64'(sel_seen), 64'(model_latency(op) == 37));
        @(negedge clk_i);
        check({tag, " ready"},   64'(ready_o), 64'd1);
        if (busy_poke) begin
            extra = 0;
            repeat (45) begin
                if (valid_o === 1'b1) extra++;
                @(negedge clk_i);
            end
            check({tag, " poke ignored"}, 64'(extra), 64'd0);
        end
    endtask

    task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int          extra;
        rst_i   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        op_i    = '0;
        op_a_i  = '0;
        op_b_i  = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle("reset", 32'd0);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(3'd5, 32'd100,        32'd7,         1'b0);
        run_op(3'd7, 32'd100,        32'd7,         1'b0);
        run_op(3'd7, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'd5,          32'd0,         1'b0);
        run_op(3'd6, 32'hFFFF_FFFB,  32'd0,         1'b0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd9,          32'd3,         1'b0);
        run_op(3'd0, 32'd3,          32'd4,         1'b0);

        // Abort in LOOP cycle 10 (cycle 12 after the start edge).
        prev = result_o;
        start_only(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (11) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort ready",  64'(ready_o), 64'd1);
        check("abort result", 64'(result_o), 64'(prev));
        extra = 0;
        repeat (40) begin
            if (valid_o === 1'b1) extra++;
            @(negedge clk_i);
        end
        check("abort no valid", 64'(extra), 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 1'b0);

        run_op(3'd1, 32'hFFFF_FFF0, 32'd5, 1'b1);
        run_op(3'd0, 32'd3, 32'd4, 1'b0);

        // Synchronous reset in the middle of LOOP.
        start_only(3'd1, 32'h7654_3210, 32'h0BAD_F00D);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_idle("mid reset", 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
